// File: rtl/locod_axil_pkg.sv
// Shared constants and state types for the accelerator control register bank.
package locod_axil_pkg;

    localparam logic [31:0] CTRL_OFF     = 32'h00;
    localparam logic [31:0] STATUS_OFF   = 32'h04;
    localparam logic [31:0] RESULT_OFF   = 32'h08;
    localparam logic [31:0] RSVD_OFF     = 32'h0C;
    localparam logic [31:0] ARG_BASE_OFF = 32'h10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int BUSY_BIT = 0;
    localparam int DONE_BIT = 1;

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    function automatic logic [31:0] arg_off(input int i);
        return ARG_BASE_OFF + 32'(4 * i);
    endfunction

endpackage

// File: rtl/axil_slave_if.sv
// AXI4-Lite channel handling: independent write/read FSMs presenting a simple
// single-cycle register access port to the bank behind it.
module axil_slave_if
    import locod_axil_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   S_AXI_awaddr,
    input  logic                S_AXI_awvalid,
    output logic                S_AXI_awready,
    input  logic [DATA_W-1:0]   S_AXI_wdata,
    input  logic [DATA_W/8-1:0] S_AXI_wstrb,
    input  logic                S_AXI_wvalid,
    output logic                S_AXI_wready,
    output logic [1:0]          S_AXI_bresp,
    output logic                S_AXI_bvalid,
    input  logic                S_AXI_bready,
    input  logic [ADDR_W-1:0]   S_AXI_araddr,
    input  logic                S_AXI_arvalid,
    output logic                S_AXI_arready,
    output logic [DATA_W-1:0]   S_AXI_rdata,
    output logic [1:0]          S_AXI_rresp,
    output logic                S_AXI_rvalid,
    input  logic                S_AXI_rready,
    output logic                reg_wr_en,
    output logic [ADDR_W-1:0]   reg_wr_addr,
    output logic [DATA_W-1:0]   reg_wr_data,
    output logic [DATA_W/8-1:0] reg_wr_strb,
    input  logic                reg_wr_err,
    output logic                reg_rd_en,
    output logic [ADDR_W-1:0]   reg_rd_addr,
    input  logic [DATA_W-1:0]   reg_rd_data,
    input  logic                reg_rd_err
);

    w_state_t             w_state;
    r_state_t             r_state;
    logic                 aw_lat, w_lat;
    logic [ADDR_W-1:0]    awaddr_q;
    logic [DATA_W-1:0]    wdata_q;
    logic [DATA_W/8-1:0]  wstrb_q;
    logic                 aw_hs, w_hs, aw_have, w_have;

    assign aw_hs   = S_AXI_awvalid && S_AXI_awready;
    assign w_hs    = S_AXI_wvalid && S_AXI_wready;
    assign aw_have = aw_lat || aw_hs;
    assign w_have  = w_lat || w_hs;

    // Commit happens on the edge that completes the second of the two handshakes.
    assign reg_wr_en   = (w_state == W_IDLE) && aw_have && w_have;
    assign reg_wr_addr = aw_lat ? awaddr_q : S_AXI_awaddr;
    assign reg_wr_data = w_lat ? wdata_q : S_AXI_wdata;
    assign reg_wr_strb = w_lat ? wstrb_q : S_AXI_wstrb;

    assign reg_rd_en   = S_AXI_arvalid && S_AXI_arready;
    assign reg_rd_addr = S_AXI_araddr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state       <= W_IDLE;
            aw_lat        <= 1'b0;
            w_lat         <= 1'b0;
            awaddr_q      <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            S_AXI_awready <= 1'b0;
            S_AXI_wready  <= 1'b0;
            S_AXI_bvalid  <= 1'b0;
            S_AXI_bresp   <= RESP_OKAY;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (reg_wr_en) begin
                        w_state       <= W_RESP;
                        aw_lat        <= 1'b0;
                        w_lat         <= 1'b0;
                        S_AXI_awready <= 1'b0;
                        S_AXI_wready  <= 1'b0;
                        S_AXI_bvalid  <= 1'b1;
                        S_AXI_bresp   <= reg_wr_err ? RESP_SLVERR : RESP_OKAY;
                    end else begin
                        if (aw_hs) begin
                            aw_lat   <= 1'b1;
                            awaddr_q <= S_AXI_awaddr;
                        end
                        if (w_hs) begin
                            w_lat   <= 1'b1;
                            wdata_q <= S_AXI_wdata;
                            wstrb_q <= S_AXI_wstrb;
                        end
                        S_AXI_awready <= !aw_have;
                        S_AXI_wready  <= !w_have;
                    end
                end
                W_RESP: begin
                    if (S_AXI_bready) begin
                        w_state       <= W_IDLE;
                        S_AXI_bvalid  <= 1'b0;
                        S_AXI_awready <= 1'b1;
                        S_AXI_wready  <= 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= R_IDLE;
            S_AXI_arready <= 1'b0;
            S_AXI_rvalid  <= 1'b0;
            S_AXI_rdata   <= '0;
            S_AXI_rresp   <= RESP_OKAY;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (reg_rd_en) begin
                        r_state       <= R_DATA;
                        S_AXI_arready <= 1'b0;
                        S_AXI_rvalid  <= 1'b1;
                        S_AXI_rdata   <= reg_rd_data;
                        S_AXI_rresp   <= reg_rd_err ? RESP_SLVERR : RESP_OKAY;
                    end else begin
                        S_AXI_arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (S_AXI_rready) begin
                        r_state       <= R_IDLE;
                        S_AXI_rvalid  <= 1'b0;
                        S_AXI_arready <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/axil_accel_ctrl_regs.sv
// AXI4-Lite control register bank for the accelerator: start pulse, args,
// busy/done handshake and captured result.
module axil_accel_ctrl_regs
    import locod_axil_pkg::*;
#(
    parameter int                        AXI_DATA_WIDTH = 32,
    parameter int                        AXI_ADDR_WIDTH = 32,
    parameter int                        NB_ARGS        = 8,
    parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = '0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [AXI_ADDR_WIDTH-1:0]         S_AXI_awaddr,
    input  logic [2:0]                        S_AXI_awprot,
    input  logic                              S_AXI_awvalid,
    output logic                              S_AXI_awready,
    input  logic [AXI_DATA_WIDTH-1:0]         S_AXI_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0]       S_AXI_wstrb,
    input  logic                              S_AXI_wvalid,
    output logic                              S_AXI_wready,
    output logic [1:0]                        S_AXI_bresp,
    output logic                              S_AXI_bvalid,
    input  logic                              S_AXI_bready,
    input  logic [AXI_ADDR_WIDTH-1:0]         S_AXI_araddr,
    input  logic [2:0]                        S_AXI_arprot,
    input  logic                              S_AXI_arvalid,
    output logic                              S_AXI_arready,
    output logic [AXI_DATA_WIDTH-1:0]         S_AXI_rdata,
    output logic [1:0]                        S_AXI_rresp,
    output logic                              S_AXI_rvalid,
    input  logic                              S_AXI_rready,
    output logic                              accel_start,
    output logic [NB_ARGS*AXI_DATA_WIDTH-1:0] accel_args,
    input  logic                              accel_done,
    input  logic [AXI_DATA_WIDTH-1:0]         accel_result
);

    localparam int AW     = AXI_ADDR_WIDTH;
    localparam int DW     = AXI_DATA_WIDTH;
    localparam int STRB_W = DW / 8;

    logic              reg_wr_en, reg_wr_err, reg_rd_en, reg_rd_err;
    logic [AW-1:0]     reg_wr_addr, reg_rd_addr, wr_al, rd_al;
    logic [DW-1:0]     reg_wr_data, reg_rd_data;
    logic [STRB_W-1:0] reg_wr_strb;

    logic                         busy, done, busy_after_done, start_fire, done_clr, wr_hit;
    logic [DW-1:0]                result;
    logic [NB_ARGS-1:0][DW-1:0]   args;
    logic                         unused_ok;

    assign unused_ok = ^{S_AXI_awprot, S_AXI_arprot, reg_rd_en};

    // Word-aligned offset from the window base; addr[1:0] never selects anything.
    function automatic logic [AW-1:0] word_off(input logic [AW-1:0] a);
        return (a - BASE_ADDR) & ~AW'(3);
    endfunction

    function automatic logic addr_ok(input logic [AW-1:0] a);
        if (a < BASE_ADDR) return 1'b0;
        return word_off(a) < AW'(ARG_BASE_OFF) + AW'(4 * NB_ARGS);
    endfunction

    axil_slave_if #(.ADDR_W(AW), .DATA_W(DW)) u_if (
        .clk(clk), .rst(rst),
        .S_AXI_awaddr(S_AXI_awaddr), .S_AXI_awvalid(S_AXI_awvalid), .S_AXI_awready(S_AXI_awready),
        .S_AXI_wdata(S_AXI_wdata), .S_AXI_wstrb(S_AXI_wstrb), .S_AXI_wvalid(S_AXI_wvalid),
        .S_AXI_wready(S_AXI_wready), .S_AXI_bresp(S_AXI_bresp), .S_AXI_bvalid(S_AXI_bvalid),
        .S_AXI_bready(S_AXI_bready), .S_AXI_araddr(S_AXI_araddr), .S_AXI_arvalid(S_AXI_arvalid),
        .S_AXI_arready(S_AXI_arready), .S_AXI_rdata(S_AXI_rdata), .S_AXI_rresp(S_AXI_rresp),
        .S_AXI_rvalid(S_AXI_rvalid), .S_AXI_rready(S_AXI_rready),
        .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
        .reg_wr_strb(reg_wr_strb), .reg_wr_err(reg_wr_err),
        .reg_rd_en(reg_rd_en), .reg_rd_addr(reg_rd_addr), .reg_rd_data(reg_rd_data),
        .reg_rd_err(reg_rd_err)
    );

    assign wr_al      = word_off(reg_wr_addr);
    assign rd_al      = word_off(reg_rd_addr);
    assign reg_wr_err = !addr_ok(reg_wr_addr);
    assign wr_hit     = reg_wr_en && !reg_wr_err;

    // A completion landing with a START write is applied first, so the START sees BUSY=0.
    assign busy_after_done = busy && !accel_done;
    assign start_fire = wr_hit && (wr_al == AW'(CTRL_OFF)) && reg_wr_strb[0] &&
                        reg_wr_data[0] && !busy_after_done;
    assign done_clr   = wr_hit && (wr_al == AW'(STATUS_OFF)) && reg_wr_strb[0] &&
                        reg_wr_data[DONE_BIT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            result      <= '0;
            accel_start <= 1'b0;
        end else begin
            accel_start <= start_fire;
            busy        <= start_fire || busy_after_done;
            if (accel_done)
                result <= accel_result;
            if (start_fire)
                done <= 1'b0;
            else if (accel_done)
                done <= 1'b1;
            else if (done_clr)
                done <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            args <= '0;
        end else if (wr_hit) begin
            for (int i = 0; i < NB_ARGS; i++)
                if (wr_al == AW'(arg_off(i)))
                    for (int b = 0; b < STRB_W; b++)
                        if (reg_wr_strb[b])
                            args[i][8*b +: 8] <= reg_wr_data[8*b +: 8];
        end
    end

    assign accel_args = args;

    always_comb begin
        reg_rd_data = '0;
        reg_rd_err  = !addr_ok(reg_rd_addr);
        if (!reg_rd_err) begin
            if (rd_al == AW'(STATUS_OFF)) begin
                reg_rd_data[BUSY_BIT] = busy;
                reg_rd_data[DONE_BIT] = done;
            end else if (rd_al == AW'(RESULT_OFF)) begin
                reg_rd_data = result;
            end else begin
                for (int i = 0; i < NB_ARGS; i++)
                    if (rd_al == AW'(arg_off(i)))
                        reg_rd_data = args[i];
            end
        end
    end

endmodule
